// File: rtl/beta_exe_lsu.sv
// Load/store unit of the exe stage: takes one memory op per lsu_en_i pulse and runs one req/gnt/rvalid bus transaction.
// Optional build macro BETA_LSU_MISALIGN_CHECK_EN: reject misaligned or reserved-size ops with a one-cycle lsu_err_o.
module beta_exe_lsu #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   lsu_en_i,
    input  logic                   lsu_op_i,
    input  logic [1:0]             lsu_op_size_i,
    input  logic                   lsu_unsigned_i,
    input  logic [DataWidth-1:0]   lsu_addr_i,
    input  logic [DataWidth-1:0]   lsu_wdata_i,
    output logic                   lsu_busy_o,
    output logic [DataWidth-1:0]   lsu_rdata_o,
    output logic                   lsu_err_o,
    output logic                   data_req_o,
    output logic                   data_we_o,
    output logic [DataWidth/8-1:0] data_be_o,
    output logic [DataWidth-1:0]   data_addr_o,
    output logic [DataWidth-1:0]   data_wdata_o,
    input  logic                   data_gnt_i,
    input  logic                   data_rvalid_i,
    input  logic [DataWidth-1:0]   data_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 op_q, op_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [1:0]           off_q, off_d;
    logic                 busy_d, req_d, we_d, err_d;
    logic [BeWidth-1:0]   be_d;
    logic [DataWidth-1:0] addr_d, wdata_d, rdata_d;

    logic                 misalign_c;
    logic [BeWidth-1:0]   be_c;
    logic [DataWidth-1:0] wdata_c;
    logic [DataWidth-1:0] shifted_c;
    logic [DataWidth-1:0] load_c;

    // Lane placement of the incoming request; lanes shifted past the top byte are dropped.
    always_comb begin
        be_c    = '0;
        wdata_c = lsu_wdata_i;
        unique case (lsu_op_size_i)
            2'b00: begin
                be_c    = BeWidth'(4'b0001 << lsu_addr_i[1:0]);
                wdata_c = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_c    = BeWidth'(4'b0011 << lsu_addr_i[1:0]);
                wdata_c = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_c    = BeWidth'(4'b1111 << lsu_addr_i[1:0]);
                wdata_c = lsu_wdata_i;
            end
        endcase
    end

`ifdef BETA_LSU_MISALIGN_CHECK_EN
    assign misalign_c = (lsu_op_size_i == 2'b11)
                     || (lsu_op_size_i == 2'b01 && lsu_addr_i[0])
                     || (lsu_op_size_i == 2'b10 && lsu_addr_i[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    // Load extraction from the latched offset and size.
    always_comb begin
        shifted_c = data_rdata_i >> {off_q, 3'b000};
        unique case (size_q)
            2'b00:   load_c = uns_q ? {24'd0, shifted_c[7:0]}
                                    : {{24{shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_c = uns_q ? {16'd0, shifted_c[15:0]}
                                    : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        busy_d  = lsu_busy_o;
        req_d   = data_req_o;
        we_d    = data_we_o;
        be_d    = data_be_o;
        addr_d  = data_addr_o;
        wdata_d = data_wdata_o;
        rdata_d = lsu_rdata_o;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (lsu_en_i) begin
                    op_d   = lsu_op_i;
                    size_d = lsu_op_size_i;
                    uns_d  = lsu_unsigned_i;
                    off_d  = lsu_addr_i[1:0];
                    busy_d = 1'b1;
                    if (misalign_c) begin
                        state_d = ERR;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = lsu_op_i;
                        be_d    = be_c;
                        addr_d  = {lsu_addr_i[DataWidth-1:2], 2'b00};
                        wdata_d = wdata_c;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (data_rvalid_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (!op_q) begin
                        rdata_d = load_c;
                    end
                end
            end
            ERR: begin
`ifdef BETA_LSU_MISALIGN_CHECK_EN
                err_d   = 1'b1;
`endif
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            op_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            lsu_busy_o   <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_err_o    <= 1'b0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= '0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            lsu_busy_o   <= busy_d;
            lsu_rdata_o  <= rdata_d;
            lsu_err_o    <= err_d;
            data_req_o   <= req_d;
            data_we_o    <= we_d;
            data_be_o    <= be_d;
            data_addr_o  <= addr_d;
            data_wdata_o <= wdata_d;
        end
    end

endmodule

// File: tb/tb_beta_exe_lsu.sv
// Scoreboard bench for beta_exe_lsu: directed ops push expected bus and completion items, monitors pop and compare.
`timescale 1ns/1ps
module tb_beta_exe_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lsu_en, lsu_op, lsu_uns;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_busy, lsu_err;
    logic [31:0] lsu_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_cyc;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          busy_cyc;
    } cmp_exp_t;

    bus_exp_t    bus_q[$];
    cmp_exp_t    cmp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Responder controls written only by the main sequence.
    int          gnt_delay = 0;
    logic [31:0] bus_rdata = '0;
    bit          hold_rvalid = 1'b0;
    int          force_req = 0;

    always #5 clk = ~clk;

    beta_exe_lsu dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .lsu_en_i       (lsu_en),
        .lsu_op_i       (lsu_op),
        .lsu_op_size_i  (lsu_size),
        .lsu_unsigned_i (lsu_uns),
        .lsu_addr_i     (lsu_addr),
        .lsu_wdata_i    (lsu_wdata),
        .lsu_busy_o     (lsu_busy),
        .lsu_rdata_o    (lsu_rdata),
        .lsu_err_o      (lsu_err),
        .data_req_o     (data_req),
        .data_we_o      (data_we),
        .data_be_o      (data_be),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_gnt_i     (data_gnt),
        .data_rvalid_i  (data_rvalid),
        .data_rdata_i   (data_rdata)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bus slave: grant after gnt_delay cycles of request, rvalid the cycle after grant.
    initial begin
        bit gnt_now;
        int rcnt;
        int force_done;
        gnt_now = 0; rcnt = 0; force_done = 0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        forever begin
            @(posedge clk); #1;
            data_gnt    = 1'b0;
            data_rvalid = 1'b0;
            if (!rstn) begin
                gnt_now = 0;
                rcnt    = 0;
            end else if (force_done != force_req) begin
                force_done  = force_req;
                data_rvalid = 1'b1;
                data_rdata  = bus_rdata;
            end else if (gnt_now) begin
                gnt_now = 0;
                if (!hold_rvalid) begin
                    data_rvalid = 1'b1;
                    data_rdata  = bus_rdata;
                end
            end else if (data_req) begin
                if (rcnt >= gnt_delay) begin
                    data_gnt = 1'b1;
                    gnt_now  = 1;
                    rcnt     = 0;
                end else begin
                    rcnt++;
                end
            end
        end
    end

    // Bus monitor: each granted request pops one expected transaction.
    initial begin
        bus_exp_t be_e;
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                wait_cnt = 0;
            end else if (data_req && !data_gnt) begin
                wait_cnt++;
            end else if (data_req && data_gnt) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got txn addr 0x%08h expected none", data_addr);
                end else begin
                    be_e = bus_q.pop_front();
                    chk("bus_we",    32'(data_we),    32'(be_e.we));
                    chk("bus_be",    32'(data_be),    32'(be_e.be));
                    chk("bus_addr",  data_addr,       be_e.addr);
                    chk("bus_wdata", data_wdata,      be_e.wdata);
                    chk("req_wait",  32'(wait_cnt),   32'(be_e.wait_cyc));
                end
                wait_cnt = 0;
            end
        end
    end

    // Completion monitor: each busy fall pops one expected result.
    initial begin
        cmp_exp_t ce;
        bit prev_busy;
        int bcnt;
        prev_busy = 0; bcnt = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_busy = 0;
                bcnt      = 0;
            end else begin
                if (lsu_busy) begin
                    bcnt++;
                end else if (prev_busy) begin
                    if (cmp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cmp_unexpected: got completion rdata 0x%08h expected none", lsu_rdata);
                    end else begin
                        ce = cmp_q.pop_front();
                        chk("rdata",     lsu_rdata,   ce.rdata);
                        chk("err",       32'(lsu_err), 32'(ce.err));
                        chk("busy_cyc",  32'(bcnt),   32'(ce.busy_cyc));
                    end
                    bcnt = 0;
                end else if (lsu_err) begin
                    checks++; errors++;
                    $display("FAIL err_spurious: got err=1 expected 0 while idle");
                end
                prev_busy = lsu_busy;
            end
        end
    end

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!lsu_busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL busy_timeout: got busy stuck high expected drop within 60 cycles");
        end
    endtask

    task automatic do_op(input logic op, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int gd, input bit bus_exp, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd, input logic eerr,
                         input int ebusy, input int extra_en);
        if (bus_exp)
            bus_q.push_back('{we: op, be: ebe, addr: {addr[31:2], 2'b00}, wdata: ewd, wait_cyc: gd});
        cmp_q.push_back('{rdata: erd, err: eerr, busy_cyc: ebusy});
        bus_rdata = rd;
        gnt_delay = gd;
        @(posedge clk); #1;
        lsu_en = 1'b1; lsu_op = op; lsu_size = sz; lsu_uns = uns;
        lsu_addr = addr; lsu_wdata = wd;
        repeat (1 + extra_en) begin
            @(posedge clk); #1;
        end
        lsu_en = 1'b0;
        wait_idle();
    endtask

    initial begin
        rstn = 1'b0;
        lsu_en = 1'b0; lsu_op = 1'b0; lsu_size = 2'b00; lsu_uns = 1'b0;
        lsu_addr = '0; lsu_wdata = '0;
        @(negedge clk);
        chk("rst_busy",  32'(lsu_busy), 32'd0);
        chk("rst_req",   32'(data_req), 32'd0);
        chk("rst_err",   32'(lsu_err),  32'd0);
        chk("rst_rdata", lsu_rdata,     32'd0);
        chk("rst_be",    32'(data_be),  32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // load word, minimum latency
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
        // load byte top lane, signed then unsigned
        do_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
        do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, 1, 4'b1000, 32'h0, 32'h00000080, 1'b0, 2, 0);
        // store half upper lane, grant delayed 3 cycles; rdata unchanged
        do_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 3, 1, 4'b1100, 32'hABCDABCD, 32'h00000080, 1'b0, 5, 0);
        // store byte lane 1
        do_op(1'b1, 2'b00, 1'b0, 32'h001, 32'h0000005A, 32'h0, 0, 1, 4'b0010, 32'h5A5A5A5A, 32'h00000080, 1'b0, 2, 0);
        // load half signed with en held while busy: one transaction only
        do_op(1'b0, 2'b01, 1'b0, 32'h002, 32'h0, 32'hBEEF1234, 0, 1, 4'b1100, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 2);
        // load half unsigned lower lane
        do_op(1'b0, 2'b01, 1'b1, 32'h000, 32'h0, 32'h1234F00D, 0, 1, 4'b0011, 32'h0, 32'h0000F00D, 1'b0, 2, 0);
        // misaligned load word
`ifdef BETA_LSU_MISALIGN_CHECK_EN
        do_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hAABBCCDD, 0, 0, 4'b0000, 32'h0, 32'h0000F00D, 1'b1, 1, 0);
`else
        do_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hAABBCCDD, 0, 1, 4'b1110, 32'h0, 32'h00AABBCC, 1'b0, 2, 0);
`endif

        // reset while waiting for the response
        bus_q.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h200, wdata: 32'h0, wait_cyc: 0});
        hold_rvalid = 1'b1;
        gnt_delay   = 0;
        bus_rdata   = 32'h55555555;
        @(posedge clk); #1;
        lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = 2'b10; lsu_uns = 1'b0;
        lsu_addr = 32'h200; lsu_wdata = 32'h0;
        @(posedge clk); #1;
        lsu_en = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("midrst_busy",  32'(lsu_busy),  32'd0);
        chk("midrst_req",   32'(data_req),  32'd0);
        chk("midrst_we",    32'(data_we),   32'd0);
        chk("midrst_be",    32'(data_be),   32'd0);
        chk("midrst_addr",  data_addr,      32'd0);
        chk("midrst_wdata", data_wdata,     32'd0);
        chk("midrst_rdata", lsu_rdata,      32'd0);
        chk("midrst_err",   32'(lsu_err),   32'd0);
        @(posedge clk); #1;
        rstn        = 1'b1;
        hold_rvalid = 1'b0;
        force_req++;
        repeat (3) @(negedge clk);
        chk("late_rvalid_busy",  32'(lsu_busy), 32'd0);
        chk("late_rvalid_rdata", lsu_rdata,     32'd0);
        chk("late_rvalid_req",   32'(data_req), 32'd0);

        // normal op after reset
        do_op(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h0BADF00D, 0, 1, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0, 2, 0);

        repeat (3) @(negedge clk);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("cmp_q_empty", 32'(cmp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
